// File: rtl/text_buffer.sv
// Character-cell text frame buffer: a ring of rows scrolled by top_row, a cursor-driven
// write port with control-code handling, and a registered scan read port with cursor blink.
module text_buffer #(
  parameter int unsigned width      = 1024,
  parameter int unsigned height     = 768,
  parameter int unsigned text_th_w  = 8,
  parameter int unsigned text_th_h  = 16,
  parameter int unsigned char_width = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  refresh,
  input  logic [$clog2(width)-1:0]              x_pixel,
  input  logic [$clog2(height)-1:0]             y_pixel,
  input  logic                                  wr_valid,
  input  logic [char_width-1:0]                 wr_char,
  output logic                                  wr_ready,
  output logic [char_width-1:0]                 cur_char,
  output logic [$clog2(width/text_th_w)-1:0]    cursor_col,
  output logic [$clog2(height/text_th_h)-1:0]   cursor_row
);

  localparam int unsigned COLS  = width / text_th_w;
  localparam int unsigned ROWS  = height / text_th_h;
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned TWB   = $clog2(text_th_w);
  localparam int unsigned THB   = $clog2(text_th_h);
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned DW    = char_width - 1;
  localparam logic [DW-1:0] Space = DW'(32);

  typedef logic [RW:0] rowx_t;
  typedef enum logic [1:0] {StIdle, StClearRow, StClearAll} state_t;

  function automatic logic [RW-1:0] wrap_row(input logic [RW-1:0] a, input logic [RW-1:0] b);
    rowx_t s;
    s = rowx_t'(a) + rowx_t'(b);
    if (s >= rowx_t'(ROWS)) s = s - rowx_t'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] top_q, top_d;
  logic [4:0]    refresh_cnt_q;
  logic          blink_q;

  logic [DW-1:0] mem [CELLS];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          accept, advance, printable;
  logic [RW-1:0] phys_row;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_srow;
  logic [AW-1:0] rd_addr;

  assign wr_ready   = (state_q == StIdle);
  assign accept     = wr_valid && wr_ready;
  assign printable  = (wr_char >= char_width'(8'h20)) && (wr_char <= char_width'(8'h7E));
  assign phys_row   = wrap_row(row_q, top_q);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  assign rd_col  = CW'(x_pixel >> TWB);
  assign rd_srow = RW'(y_pixel >> THB);
  assign rd_addr = cell_addr(wrap_row(rd_srow, top_q), rd_col);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    wr_en   = 1'b0;
    wr_addr = cell_addr(phys_row, col_q);
    wr_data = Space;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (printable) begin
            wr_en   = 1'b1;
            wr_data = wr_char[DW-1:0];
            if (col_q == CW'(COLS - 1)) begin
              col_d   = '0;
              advance = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (wr_char == char_width'(8'h0A)) begin
            col_d   = '0;
            advance = 1'b1;
          end else if (wr_char == char_width'(8'h0D)) begin
            col_d = '0;
          end else if (wr_char == char_width'(8'h08)) begin
            if (col_q != '0) begin
              col_d   = col_q - 1'b1;
              wr_en   = 1'b1;
              wr_addr = cell_addr(phys_row, col_q - 1'b1);
            end
          end else if (wr_char == char_width'(8'h0C)) begin
            state_d = StClearAll;
            cnt_d   = '0;
            col_d   = '0;
            row_d   = '0;
            top_d   = '0;
          end
        end
      end
      StClearRow: begin
        // row_q sits at the bottom and top_q has already moved, so phys_row is the freed row
        wr_en   = 1'b1;
        wr_addr = cell_addr(phys_row, cnt_q[CW-1:0]);
        if (cnt_q == AW'(COLS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClearAll: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        if (cnt_q == AW'(CELLS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StClearAll;
        cnt_d   = '0;
      end
    endcase
    if (advance) begin
      if (row_q == RW'(ROWS - 1)) begin
        top_d   = wrap_row(top_q, RW'(1));
        state_d = StClearRow;
        cnt_d   = '0;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StClearAll;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      top_q         <= '0;
      refresh_cnt_q <= '0;
      blink_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      if (refresh) begin
        refresh_cnt_q <= refresh_cnt_q + 1'b1;
        if (refresh_cnt_q == 5'd31) blink_q <= ~blink_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a same-cycle write to the scanned cell is not visible yet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_char <= '0;
    end else begin
      cur_char <= {blink_q && (rd_col == col_q) && (rd_srow == row_q), mem[rd_addr]};
    end
  end

endmodule
